// File: rtl/mem_arbiter.sv
// mem_arbiter: arbitrates the single shared memory port between the
// instruction-fetch path and the load/store path. It sequences each access
// through SETUP (MAR/MDR load), ACCESS (rd/wr held for MEM_LAT cycles) and
// DONE (one-cycle acknowledge to the winning requester).
module mem_arbiter #(
    parameter int WIDTH   = 32,
    parameter int MEM_LAT = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             f_req,
    input  logic [WIDTH-1:0] f_addr,
    output logic             f_ack,
    output logic [WIDTH-1:0] f_rdata,
    input  logic             ls_req,
    input  logic             ls_we,
    input  logic [WIDTH-1:0] ls_addr,
    input  logic [WIDTH-1:0] ls_wdata,
    output logic             ls_ack,
    output logic [WIDTH-1:0] ls_rdata,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    input  logic [WIDTH-1:0] mem_rdata,
    output logic             marEn,
    output logic             mdrEn,
    output logic             rd,
    output logic             wr,
    output logic             busy
);

    localparam int CNT_W = $clog2(MEM_LAT) + 1;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        DONE
    } stateT;

    typedef enum logic {
        OWNER_F,
        OWNER_LS
    } ownerT;

    stateT             state;
    stateT             nextState;
    ownerT             owner;
    ownerT             lastOwner;
    logic              weReg;
    logic [CNT_W-1:0]  cnt;
    logic              anyReq;
    logic              grantFetch;
    logic              accessEnd;

    // Arbitration: a lone requester wins; on a tie the side not granted last wins.
    always_comb begin
        anyReq     = f_req | ls_req;
        grantFetch = f_req && (!ls_req || (lastOwner == OWNER_LS));
        accessEnd  = (cnt == '0);
    end

    // State register; reset abandons any transaction in flight.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next-state logic and Moore decode of strobes and acknowledges.
    always_comb begin
        nextState = state;
        busy      = 1'b0;
        marEn     = 1'b0;
        mdrEn     = 1'b0;
        rd        = 1'b0;
        wr        = 1'b0;
        f_ack     = 1'b0;
        ls_ack    = 1'b0;
        case (state)
            IDLE: begin
                if (anyReq) begin
                    nextState = SETUP;
                end
            end
            SETUP: begin
                busy      = 1'b1;
                marEn     = 1'b1;
                mdrEn     = weReg;
                nextState = ACCESS;
            end
            ACCESS: begin
                busy = 1'b1;
                rd   = !weReg;
                wr   = weReg;
                if (accessEnd) begin
                    nextState = DONE;
                end
            end
            DONE: begin
                busy      = 1'b1;
                f_ack     = (owner == OWNER_F);
                ls_ack    = (owner == OWNER_LS);
                nextState = IDLE;
            end
            default: begin
                nextState = IDLE;
            end
        endcase
    end

    // Grant capture (owner, direction, MAR/MDR), access countdown and read-data return.
    always_ff @(posedge clk) begin
        if (!reset) begin
            owner     <= OWNER_F;
            lastOwner <= OWNER_LS;
            weReg     <= 1'b0;
            cnt       <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            f_rdata   <= '0;
            ls_rdata  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (anyReq) begin
                        owner     <= grantFetch ? OWNER_F : OWNER_LS;
                        lastOwner <= grantFetch ? OWNER_F : OWNER_LS;
                        weReg     <= grantFetch ? 1'b0 : ls_we;
                        mem_addr  <= grantFetch ? f_addr : ls_addr;
                        cnt       <= CNT_W'(MEM_LAT - 1);
                        if (!grantFetch && ls_we) begin
                            mem_wdata <= ls_wdata;
                        end
                    end
                end
                ACCESS: begin
                    if (accessEnd) begin
                        if (!weReg) begin
                            if (owner == OWNER_F) begin
                                f_rdata <= mem_rdata;
                            end else begin
                                ls_rdata <= mem_rdata;
                            end
                        end
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed stimulus for mem_arbiter, checked every cycle
// against a transaction-age model plus hand-computed literal expectations.
module tb_mem_arbiter;

    localparam int WIDTH   = 32;
    localparam int MEM_LAT = 2;

    logic             clk = 1'b0;
    logic             reset;
    logic             f_req;
    logic [WIDTH-1:0] f_addr;
    logic             f_ack;
    logic [WIDTH-1:0] f_rdata;
    logic             ls_req;
    logic             ls_we;
    logic [WIDTH-1:0] ls_addr;
    logic [WIDTH-1:0] ls_wdata;
    logic             ls_ack;
    logic [WIDTH-1:0] ls_rdata;
    logic [WIDTH-1:0] mem_addr;
    logic [WIDTH-1:0] mem_wdata;
    logic [WIDTH-1:0] mem_rdata;
    logic             marEn;
    logic             mdrEn;
    logic             rd;
    logic             wr;
    logic             busy;

    int total = 0;
    int bad   = 0;

    mem_arbiter #(.WIDTH(WIDTH), .MEM_LAT(MEM_LAT)) dut (
        .clk(clk), .reset(reset),
        .f_req(f_req), .f_addr(f_addr), .f_ack(f_ack), .f_rdata(f_rdata),
        .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
        .ls_ack(ls_ack), .ls_rdata(ls_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .marEn(marEn), .mdrEn(mdrEn), .rd(rd), .wr(wr), .busy(busy)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    always #5 clk = ~clk;

    // Model state: a transaction is described only by its age in cycles since grant.
    logic             mValid = 1'b0;
    logic             mActive;
    int               mAge;
    logic             mOwnerF;
    logic             mWe;
    logic             mLastLs;
    logic [WIDTH-1:0] eAddr;
    logic [WIDTH-1:0] eWdata;
    logic [WIDTH-1:0] eFRdata;
    logic [WIDTH-1:0] eLsRdata;
    wire              modelPickF = f_req && (!ls_req || mLastLs);

    // Behavioural model: grant on any request while idle, retire at age MEM_LAT+2.
    always @(posedge clk) begin
        if (!reset) begin
            mValid   <= 1'b1;
            mActive  <= 1'b0;
            mAge     <= 0;
            mOwnerF  <= 1'b0;
            mWe      <= 1'b0;
            mLastLs  <= 1'b1;
            eAddr    <= '0;
            eWdata   <= '0;
            eFRdata  <= '0;
            eLsRdata <= '0;
        end else if (!mActive) begin
            if (f_req || ls_req) begin
                mActive <= 1'b1;
                mAge    <= 1;
                mOwnerF <= modelPickF;
                mLastLs <= !modelPickF;
                mWe     <= modelPickF ? 1'b0 : ls_we;
                eAddr   <= modelPickF ? f_addr : ls_addr;
                if (!modelPickF && ls_we) eWdata <= ls_wdata;
            end
        end else begin
            if (mAge == MEM_LAT + 1 && !mWe) begin
                if (mOwnerF) eFRdata <= mem_rdata;
                else         eLsRdata <= mem_rdata;
            end
            if (mAge == MEM_LAT + 2) mActive <= 1'b0;
            else                     mAge <= mAge + 1;
        end
    end

    task automatic checkOutput(input string name, input logic [WIDTH-1:0] act,
                               input logic [WIDTH-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    // Per-cycle comparison of every output against the model, away from the rising edge.
    always @(negedge clk) begin
        if (mValid) begin
            checkOutput("busy",      busy,      mActive);
            checkOutput("marEn",     marEn,     mActive && mAge == 1);
            checkOutput("mdrEn",     mdrEn,     mActive && mAge == 1 && mWe);
            checkOutput("rd",        rd,        mActive && mAge >= 2 && mAge <= MEM_LAT + 1 && !mWe);
            checkOutput("wr",        wr,        mActive && mAge >= 2 && mAge <= MEM_LAT + 1 && mWe);
            checkOutput("f_ack",     f_ack,     mActive && mAge == MEM_LAT + 2 && mOwnerF);
            checkOutput("ls_ack",    ls_ack,    mActive && mAge == MEM_LAT + 2 && !mOwnerF);
            checkOutput("mem_addr",  mem_addr,  eAddr);
            checkOutput("mem_wdata", mem_wdata, eWdata);
            checkOutput("f_rdata",   f_rdata,   eFRdata);
            checkOutput("ls_rdata",  ls_rdata,  eLsRdata);
        end
    end

    task automatic applyStimulus(input logic r, input logic fr, input logic [WIDTH-1:0] fa,
                                 input logic lr, input logic lw, input logic [WIDTH-1:0] la,
                                 input logic [WIDTH-1:0] lwd, input logic [WIDTH-1:0] mrd);
        reset     = r;
        f_req     = fr;
        f_addr    = fa;
        ls_req    = lr;
        ls_we     = lw;
        ls_addr   = la;
        ls_wdata  = lwd;
        mem_rdata = mrd;
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Directed scenario; inputs change only on falling edges, cycle numbers are relative to the fetch grant.
    initial begin
        applyStimulus(1'b0, 1'b1, 32'h100, 1'b1, 1'b0, 32'h20, 32'h0, 32'hDEADBEEF);
        waitCycles(2);
        checkOutput("reset busy",     busy,     1'b0);
        checkOutput("reset rd",       rd,       1'b0);
        checkOutput("reset f_ack",    f_ack,    1'b0);
        checkOutput("reset mem_addr", mem_addr, 32'h0);
        checkOutput("reset ls_rdata", ls_rdata, 32'h0);
        reset = 1'b1;

        waitCycles(1);
        checkOutput("fetch setup marEn", marEn,    1'b1);
        checkOutput("fetch mem_addr",    mem_addr, 32'h100);
        checkOutput("fetch mdrEn",       mdrEn,    1'b0);
        ls_req = 1'b0;
        waitCycles(1);
        checkOutput("fetch rd c2", rd, 1'b1);
        checkOutput("fetch wr c2", wr, 1'b0);
        waitCycles(1);
        checkOutput("fetch rd c3", rd, 1'b1);
        waitCycles(1);
        checkOutput("fetch f_ack c4",  f_ack,   1'b1);
        checkOutput("fetch ls_ack c4", ls_ack,  1'b0);
        checkOutput("fetch f_rdata",   f_rdata, 32'hDEADBEEF);
        applyStimulus(1'b1, 1'b0, 32'h100, 1'b1, 1'b1, 32'h20, 32'h12345678, 32'hDEADBEEF);

        waitCycles(1);
        checkOutput("idle between busy", busy, 1'b0);
        waitCycles(1);
        checkOutput("store marEn",     marEn,     1'b1);
        checkOutput("store mdrEn",     mdrEn,     1'b1);
        checkOutput("store mem_addr",  mem_addr,  32'h20);
        checkOutput("store mem_wdata", mem_wdata, 32'h12345678);
        waitCycles(1);
        checkOutput("store wr", wr, 1'b1);
        checkOutput("store rd", rd, 1'b0);
        waitCycles(2);
        checkOutput("store ls_ack",   ls_ack,   1'b1);
        checkOutput("store ls_rdata", ls_rdata, 32'h0);
        applyStimulus(1'b1, 1'b1, 32'h100, 1'b1, 1'b0, 32'h40, 32'h12345678, 32'hCAFE0001);

        for (int k = 0; k < 4; k++) begin
            waitCycles(5);
            if (k % 2 == 0) begin
                checkOutput("contention f_ack",   f_ack,   1'b1);
                checkOutput("contention ls_ack",  ls_ack,  1'b0);
                checkOutput("contention f_rdata", f_rdata, 32'hCAFE0001 + k);
            end else begin
                checkOutput("contention ls_ack",   ls_ack,   1'b1);
                checkOutput("contention f_ack",    f_ack,    1'b0);
                checkOutput("contention ls_rdata", ls_rdata, 32'hCAFE0001 + k);
            end
            mem_rdata = 32'hCAFE0002 + k;
        end
        applyStimulus(1'b1, 1'b0, 32'h100, 1'b1, 1'b0, 32'h80, 32'h12345678, 32'h55AA55AA);

        waitCycles(3);
        checkOutput("midop rd before reset", rd, 1'b1);
        reset = 1'b0;
        waitCycles(1);
        checkOutput("midop busy",     busy,     1'b0);
        checkOutput("midop rd",       rd,       1'b0);
        checkOutput("midop ls_ack",   ls_ack,   1'b0);
        checkOutput("midop ls_rdata", ls_rdata, 32'h0);
        reset = 1'b1;
        waitCycles(4);
        checkOutput("regrant ls_ack",   ls_ack,   1'b1);
        checkOutput("regrant ls_rdata", ls_rdata, 32'h55AA55AA);
        checkOutput("regrant mem_addr", mem_addr, 32'h80);
        applyStimulus(1'b1, 1'b1, 32'h100, 1'b0, 1'b0, 32'h80, 32'h12345678, 32'h0BAD0001);

        waitCycles(3);
        f_addr = 32'h200;
        waitCycles(1);
        checkOutput("stable mem_addr access", mem_addr, 32'h100);
        waitCycles(1);
        checkOutput("stable mem_addr done", mem_addr, 32'h100);
        checkOutput("stable f_ack",         f_ack,    1'b1);
        checkOutput("stable f_rdata",       f_rdata,  32'h0BAD0001);
        waitCycles(2);
        checkOutput("second fetch marEn",    marEn,    1'b1);
        checkOutput("second fetch mem_addr", mem_addr, 32'h200);
        waitCycles(3);
        checkOutput("second fetch f_ack", f_ack, 1'b1);
        f_req = 1'b0;
        waitCycles(3);
        checkOutput("final idle busy", busy, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Sequencer and arbiter for the CPU's single shared memory port. It arbitrates between the instruction-fetch path and the load/store path and drives the MAR/MDR enables and the rd/wr strobes through a fixed-latency access. It returns read data and a one-cycle acknowledge to the winning requester. The block sits between the main controller's fetch and load/store sequencing and the memory interface of the 32-bit datapath.

## Interface
- WIDTH, 32, address/data width
- MEM_LAT, 2, cycles rd/wr held asserted per access (≥1; 0 is illegal)

- clk  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-low reset
- f_req  in  1  fetch request, level, held until f_ack
- f_addr  in  WIDTH  fetch address
- f_ack  out  1  one-cycle pulse, fetch transaction complete
- f_rdata  out  WIDTH  fetch read data, valid from f_ack, held until next fetch completes
- ls_req  in  1  load/store request, level, held until ls_ack
- ls_we  in  1  1 = store, 0 = load
- ls_addr  in  WIDTH  load/store address
- ls_wdata  in  WIDTH  store data
- ls_ack  out  1  one-cycle pulse, load/store complete
- ls_rdata  out  WIDTH  load data, valid from ls_ack, held until next load completes
- mem_addr  out  WIDTH  captured address (MAR value)
- mem_wdata  out  WIDTH  captured store data (MDR value)
- mem_rdata  in  WIDTH  memory read data
- marEn  out  1  MAR load enable
- mdrEn  out  1  MDR load enable (stores only)
- rd  out  1  memory read strobe
- wr  out  1  memory write strobe
- busy  out  1  high in any state but IDLE

## Operation
- FSM states: IDLE, SETUP, ACCESS, DONE. All strobe and ack outputs are Moore, decoded from state and captured owner/we.
- IDLE: no strobes. If any request is high, grant, capture owner, we, address and wdata (wdata only on a store), load cnt = MEM_LAT-1, then go to SETUP. With no request, stay in IDLE.
- Arbitration: a lone requester wins. When both request, the requester not granted last wins. last_owner updates on every grant and resets to LS, so fetch wins the first tie. Fetch transactions always read (we=0).
- SETUP (1 cycle): marEn=1. mdrEn=1 if we. Then go to ACCESS.
- ACCESS (MEM_LAT cycles): rd=1 for a read, wr=1 for a store. cnt decrements each cycle. At cnt==0, go to DONE; on that edge, a read captures mem_rdata into the owner's rdata register.
- DONE (1 cycle): ack to owner (f_ack or ls_ack). Then go to IDLE.
- Requests, addresses and data are ignored outside IDLE. Values are sampled only at grant.
- A requester drops req on the edge ending its DONE cycle. If req is still high in the following IDLE cycle, it is a new request.
- cnt width is $clog2(MEM_LAT)+1. mem_addr and mem_wdata hold their values until the next grant.

## Timing
- Reset (reset=0 at an edge, in any state): next state IDLE. busy, marEn, mdrEn, rd, wr, f_ack and ls_ack = 0. mem_addr, mem_wdata, f_rdata and ls_rdata = 0. last_owner = LS, cnt = 0.
- Reset mid-transaction abandons the transaction: no ack and no rdata update. Pending requests are re-arbitrated after reset releases.
- Latency with request high in IDLE cycle 0:
  - SETUP in cycle 1.
  - ACCESS in cycles 2..MEM_LAT+1.
  - DONE/ack in cycle MEM_LAT+2.
  - Next grant possible in IDLE cycle MEM_LAT+3.
- Throughput is one transaction per MEM_LAT+3 cycles.
- Never both rd and wr. Never both acks. Strobes never overlap ack.

## Test plan
- Reset: hold reset=0 for 2 cycles with both reqs high → all outputs 0, busy=0. Release → fetch granted first.
- Fetch read, MEM_LAT=2, f_addr=0x100, mem_rdata=0xDEADBEEF → mem_addr=0x100, marEn cycle 1, rd cycles 2–3, f_ack cycle 4, f_rdata=0xDEADBEEF, ls_ack never, wr never.
- Store: ls_we=1, ls_addr=0x20, ls_wdata=0x12345678 → marEn=mdrEn=1 in SETUP, mem_wdata=0x12345678, wr 2 cycles, ls_ack cycle 4, rd never, ls_rdata unchanged.
- Contention: both reqs held high continuously, each re-asserted after its ack → grants F, LS, F, LS; acks 5 cycles apart at cycles 4, 9, 14, 19.
- Reset mid-op: reset=0 during the first ACCESS cycle of a load → next cycle IDLE, rd=0, no ls_ack, ls_rdata=0. The request still pending is granted after release.
- Address/data stability: change f_addr from 0x100 to 0x200 during ACCESS → mem_addr stays 0x100 through DONE. Back-to-back fetch with f_req held → second grant uses 0x200.
